// File: rtl/hazard_unit_mc.sv
// Hazard unit for the 5-stage RV32 pipeline: forwarding, load-use/RAW stalls,
// control flushes, and a two-state FSM that freezes F/D/E while the iterative mul/div runs.
module hazard_unit_mc #(
    parameter int REG_AW     = 5,
    parameter int FWD_EN     = 1,
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic [REG_AW-1:0] RdM,
    input  logic [REG_AW-1:0] RdW,
    input  logic              RegWriteE,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic [1:0]        ResultSrcE,
    input  logic [1:0]        PcSrc,
    input  logic              MdValidE,
    input  logic              MdDone,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushM,
    output logic              MdStart,
    output logic              MdTimeout,
    output logic [CNT_W-1:0]  StallCount,
    output logic              md_state
);

    localparam int BW = $clog2(MD_TIMEOUT + 1);
    localparam logic [BW-1:0] TIMEOUT_VAL = BW'(MD_TIMEOUT);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_t;

    md_state_t     state;
    md_state_t     state_next;
    logic [BW-1:0] busy_cnt;

    logic timeout_hit;
    logic md_hold;
    logic load_use;
    logic raw_stall;
    logic ctrl_flush;
    logic d_stall;

    // Register x0 is hardwired to zero, so it never creates a dependency.
    function automatic logic reg_hit(input logic [REG_AW-1:0] rd,
                                     input logic [REG_AW-1:0] rs);
        return (rd != '0) && (rd == rs);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs);
        logic [1:0] sel;
        sel = 2'b00;
        if (FWD_EN != 0) begin
            if (RegWriteM && reg_hit(RdM, rs)) begin
                sel = 2'b01;
            end else if (RegWriteW && reg_hit(RdW, rs)) begin
                sel = 2'b10;
            end
        end
        return sel;
    endfunction

    assign md_state = (state == BUSY);

    assign timeout_hit = (state == BUSY) && !MdDone && (busy_cnt == TIMEOUT_VAL);

    assign md_hold = ((state == IDLE) && MdValidE) ||
                     ((state == BUSY) && !MdDone && !timeout_hit);

    assign load_use = (ResultSrcE == 2'b01) &&
                      (reg_hit(RdE, Rs1D) || reg_hit(RdE, Rs2D));

    assign raw_stall = (FWD_EN == 0) &&
                       ((RegWriteE && (reg_hit(RdE, Rs1D) || reg_hit(RdE, Rs2D))) ||
                        (RegWriteM && (reg_hit(RdM, Rs1D) || reg_hit(RdM, Rs2D))));

    assign ctrl_flush = (PcSrc != 2'b00);

    // A taken branch discards D anyway, so stalling it would only waste a cycle.
    assign d_stall = (load_use || raw_stall) && !ctrl_flush;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (MdValidE) state_next = BUSY;
            BUSY: if (MdDone || timeout_hit) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushM    = 1'b0;
        MdStart   = 1'b0;
        if (reset) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushM = 1'b1;
        end else begin
            ForwardAE = fwd_sel(Rs1E);
            ForwardBE = fwd_sel(Rs2E);
            if (md_hold) begin
                // EX holds the mul/div op; bubbles go into MEM until it completes.
                StallF  = 1'b1;
                StallD  = 1'b1;
                StallE  = 1'b1;
                FlushM  = 1'b1;
                MdStart = (state == IDLE);
            end else begin
                StallF = d_stall;
                StallD = d_stall;
                FlushD = ctrl_flush;
                FlushE = ctrl_flush || d_stall;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            busy_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE) begin
                if (MdValidE) busy_cnt <= BW'(1);
            end else if (!MdDone && !timeout_hit) begin
                busy_cnt <= busy_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            MdTimeout <= 1'b0;
        end else if (timeout_hit) begin
            MdTimeout <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            StallCount <= '0;
        end else if (StallF && (StallCount != {CNT_W{1'b1}})) begin
            StallCount <= StallCount + 1'b1;
        end
    end

endmodule
